// File: rtl/if_id_pipeline_ctrl_pkg.sv
// Shared definitions for the IF/ID pipeline controller: FSM encodings,
// the NOP word, the default reset PC and the packed IF/ID latch layout.
package if_id_pipeline_ctrl_pkg;

  localparam logic [1:0]  ST_RUN   = 2'd0;
  localparam logic [1:0]  ST_STALL = 2'd1;
  localparam logic [1:0]  ST_FLUSH = 2'd2;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_pipeline_ctrl_pipe_reg.sv
// Width-parameterised pipeline register with enable and clear; clear
// outranks enable, reset outranks both.
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_pipeline_ctrl.sv
// Applies hazard-unit controls to the PC, the IF/ID latch and the ID control
// bubble mux; keeps stall/flush statistics and a sticky stall watchdog.
module if_id_pipeline_ctrl
  import if_id_pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          CTRL_W    = 9,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 4
) (
  input  logic              inClk,
  input  logic              inReset,
  input  logic              inPCWrite,
  input  logic              inIF_IDWrite,
  input  logic              inIF_Flush,
  input  logic              inStall,
  input  logic              inPCSrc,
  input  logic [31:0]       inBranchTarget,
  input  logic [31:0]       inInstr,
  input  logic [CTRL_W-1:0] inIDCtrl,
  output logic [31:0]       outPC,
  output logic [31:0]       outIF_IDPC4,
  output logic [31:0]       outIF_IDInstr,
  output logic              outIF_IDValid,
  output logic [CTRL_W-1:0] outIDCtrl,
  output logic [1:0]        outState,
  output logic [CNT_W-1:0]  outStallCount,
  output logic [CNT_W-1:0]  outFlushCount,
  output logic              outStallTimeout
);

  logic [31:0]      w_pc;
  logic [31:0]      w_pc_next;
  ifid_t            w_ifid_d;
  ifid_t            w_ifid_q;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_run;
  logic             r_timeout;

  // ---- fetch stage: PC register ----
  assign w_pc_next = inPCSrc ? inBranchTarget : pc_plus4(w_pc);

  pipe_reg #(
    .W       (32),
    .RST_VAL (RESET_PC)
  ) u_pc (
    .i_clk (inClk),
    .i_rst (inReset),
    .i_en  (inPCWrite),
    .i_clr (1'b0),
    .i_d   (w_pc_next),
    .o_q   (w_pc)
  );

  // ---- IF/ID boundary: flush clears to a NOP bubble ahead of write ----
  always_comb begin
    w_ifid_d       = '0;
    w_ifid_d.valid = 1'b1;
    w_ifid_d.pc4   = pc_plus4(w_pc);
    w_ifid_d.instr = inInstr;
  end

  pipe_reg #(
    .W       ($bits(ifid_t)),
    .RST_VAL ('0)
  ) u_ifid (
    .i_clk (inClk),
    .i_rst (inReset),
    .i_en  (inIF_IDWrite),
    .i_clr (inIF_Flush),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  assign outIDCtrl = inStall ? inIDCtrl : '0;

  always_ff @(posedge inClk) begin
    if (inReset) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN, ST_STALL, ST_FLUSH: begin
          if (inIF_Flush)      r_state <= ST_FLUSH;
          else if (!inPCWrite) r_state <= ST_STALL;
          else                 r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Statistics counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!inPCWrite && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (inIF_Flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Run length is capped at MAX_STALL; the flag fires one edge after reaching it.
  always_ff @(posedge inClk) begin
    if (inReset) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_run >= CNT_W'(MAX_STALL)) r_timeout <= 1'b1;
      if (inPCWrite)                       r_run <= '0;
      else if (r_run < CNT_W'(MAX_STALL))  r_run <= r_run + 1'b1;
    end
  end

  assign outPC           = w_pc;
  assign outIF_IDPC4     = w_ifid_q.pc4;
  assign outIF_IDInstr   = w_ifid_q.instr;
  assign outIF_IDValid   = w_ifid_q.valid;
  assign outState        = r_state;
  assign outStallCount   = r_stall_cnt;
  assign outFlushCount   = r_flush_cnt;
  assign outStallTimeout = r_timeout;

endmodule

// File: tb/tb_if_id_pipeline_ctrl.sv
// Directed and randomized bench for if_id_pipeline_ctrl against a
// behavioural model of the fetch/IF-ID rules.
module tb_if_id_pipeline_ctrl;

  localparam int CTRL_W    = 9;
  localparam int CNT_W     = 16;
  localparam int MAX_STALL = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              inClk = 1'b0;
  logic              inReset;
  logic              inPCWrite;
  logic              inIF_IDWrite;
  logic              inIF_Flush;
  logic              inStall;
  logic              inPCSrc;
  logic [31:0]       inBranchTarget;
  logic [31:0]       inInstr;
  logic [CTRL_W-1:0] inIDCtrl;
  logic [31:0]       outPC;
  logic [31:0]       outIF_IDPC4;
  logic [31:0]       outIF_IDInstr;
  logic              outIF_IDValid;
  logic [CTRL_W-1:0] outIDCtrl;
  logic [1:0]        outState;
  logic [CNT_W-1:0]  outStallCount;
  logic [CNT_W-1:0]  outFlushCount;
  logic              outStallTimeout;

  if_id_pipeline_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .CTRL_W    (CTRL_W),
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .inClk           (inClk),
    .inReset         (inReset),
    .inPCWrite       (inPCWrite),
    .inIF_IDWrite    (inIF_IDWrite),
    .inIF_Flush      (inIF_Flush),
    .inStall         (inStall),
    .inPCSrc         (inPCSrc),
    .inBranchTarget  (inBranchTarget),
    .inInstr         (inInstr),
    .inIDCtrl        (inIDCtrl),
    .outPC           (outPC),
    .outIF_IDPC4     (outIF_IDPC4),
    .outIF_IDInstr   (outIF_IDInstr),
    .outIF_IDValid   (outIF_IDValid),
    .outIDCtrl       (outIDCtrl),
    .outState        (outState),
    .outStallCount   (outStallCount),
    .outFlushCount   (outFlushCount),
    .outStallTimeout (outStallTimeout)
  );

  always #5 inClk = ~inClk;

  // Reference model state, in plain integers.
  longint m_pc, m_pc4, m_instr;
  int     m_valid, m_state, m_stall, m_flush, m_run, m_timeout;
  int     n_total = 0;
  int     n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_in(input bit rst, input bit pcw, input bit ifw, input bit fl,
                        input bit st, input bit src, input logic [31:0] tgt,
                        input logic [31:0] ins);
    inReset = rst; inPCWrite = pcw; inIF_IDWrite = ifw; inIF_Flush = fl;
    inStall = st; inPCSrc = src; inBranchTarget = tgt; inInstr = ins;
    inIDCtrl = CTRL_W'($urandom);
  endtask

  task automatic model_edge();
    if (inReset) begin
      m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_state = 0;
      m_stall = 0; m_flush = 0; m_run = 0; m_timeout = 0;
    end else begin
      if (inIF_Flush) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (inIF_IDWrite) begin
        m_instr = inInstr; m_pc4 = (m_pc + 4) % 64'h1_0000_0000; m_valid = 1;
      end
      if (inPCWrite) m_pc = inPCSrc ? inBranchTarget : (m_pc + 4) % 64'h1_0000_0000;
      m_state = inIF_Flush ? 2 : (!inPCWrite ? 1 : 0);
      if (!inPCWrite) m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (inIF_Flush) m_flush = (m_flush + 1 > CNT_MAX) ? CNT_MAX : m_flush + 1;
      if (m_run >= MAX_STALL) m_timeout = 1;
      m_run = inPCWrite ? 0 : m_run + 1;
    end
  endtask

  task automatic step(input string tag);
    #1;
    check({tag, ":idctrl"}, 32'(outIDCtrl), inStall ? 32'(inIDCtrl) : 32'd0);
    @(posedge inClk);
    model_edge();
    #1;
    check({tag, ":pc"},      outPC,                  m_pc[31:0]);
    check({tag, ":pc4"},     outIF_IDPC4,            m_pc4[31:0]);
    check({tag, ":instr"},   outIF_IDInstr,          m_instr[31:0]);
    check({tag, ":valid"},   32'(outIF_IDValid),     32'(m_valid));
    check({tag, ":state"},   32'(outState),          32'(m_state));
    check({tag, ":stallc"},  32'(outStallCount),     32'(m_stall));
    check({tag, ":flushc"},  32'(outFlushCount),     32'(m_flush));
    check({tag, ":timeout"}, 32'(outStallTimeout),   32'(m_timeout));
  endtask

  initial begin
    set_in(1, 1, 1, 0, 1, 0, 32'h0, 32'h0);
    @(posedge inClk);
    step("reset");
    check("reset_pc_direct", outPC, 32'h0);

    // Three free-running fetches
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h1111_0001); step("free1");
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h1111_0002); step("free2");
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h1111_0003); step("free3");
    check("free_pc12", outPC, 32'd12);

    // Load-use bubble
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'hDEAD_0000); step("loaduse");
    check("loaduse_state", 32'(outState), 32'd1);
    check("loaduse_stallc", 32'(outStallCount), 32'd1);
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h2222_0001); step("after_lu");

    // Taken branch with flush
    set_in(0, 1, 1, 1, 1, 1, 32'h40, 32'hBAD0_0001); step("branch");
    check("branch_pc", outPC, 32'h40);
    check("branch_valid", 32'(outIF_IDValid), 32'd0);

    // Flush beats a held IF/ID and held PC
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h3333_0001); step("pre_conf");
    set_in(0, 0, 0, 1, 1, 0, 32'h0, 32'h3333_0002); step("conflict");
    check("conflict_state", 32'(outState), 32'd2);
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h3333_0003); step("post_conf");

    // Watchdog: five consecutive stalls
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h4444_0000);
      step("wd_stall");
    end
    check("wd_fired", 32'(outStallTimeout), 32'd1);
    set_in(0, 1, 1, 0, 1, 0, 32'h0, 32'h4444_0001); step("wd_sticky");
    check("wd_sticky_direct", 32'(outStallTimeout), 32'd1);

    // Reset in the middle of a stall run
    set_in(0, 0, 0, 0, 0, 0, 32'h0, 32'h5555_0000); step("pre_rst");
    set_in(1, 0, 0, 1, 0, 1, 32'h80, 32'h5555_0001); step("mid_rst");
    check("mid_rst_timeout", 32'(outStallTimeout), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom & 32'hFFFF_FFFC, $urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
